// File: rtl/nes_video_pkg.sv
// Shared video-block types for the palette loading path.
// Entry layout and palette geometry live here so both sides agree.
package nes_video_pkg;

    localparam int PAL_ENTRIES = 64;
    localparam int PAL_BYTES   = 192;

    typedef struct packed {
        logic [5:0]  index;
        logic [23:0] rgb;
    } pal_entry_t;

    typedef enum logic {
        IDLE,
        WRITE
    } drain_state_e;

endpackage

// File: rtl/palette_loader_if.sv
// Download stream, video timing and palette write port of the loader.
// master drives the download/timing side, slave is the loader itself.
interface palette_loader_if;

    logic        dl_start;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic        hblank;
    logic        vblank;
    logic        video_reset;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic        done;

    modport master (
        output dl_start, dl_wr, dl_data,
        output hblank, vblank, video_reset,
        input  dl_wait, load_color,
        input  load_color_index, load_color_data, done
    );

    modport slave (
        input  dl_start, dl_wr, dl_data,
        input  hblank, vblank, video_reset,
        output dl_wait, load_color,
        output load_color_index, load_color_data, done
    );

endinterface

// File: rtl/pal_wr_fifo.sv
// Pending palette-entry queue with registered full/empty flags.
// Flush discards everything queued in a single cycle.
module pal_wr_fifo
    import nes_video_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  pal_entry_t din_i,
    input  logic       pop_i,
    output pal_entry_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    pal_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          full_q;
    logic          empty_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;
    assign cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/palette_loader.sv
// Assembles R,G,B download bytes into palette entries and writes them
// into the video palette only while the palette is not being read.
module palette_loader
    import nes_video_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    palette_loader_if.slave  bus
);

    drain_state_e state_q, state_d;
    logic [1:0]   phase_q, phase_d;
    logic [7:0]   r_q, r_d;
    logic [7:0]   g_q, g_d;
    logic [6:0]   idx_q, idx_d;
    logic [6:0]   written_q, written_d;
    logic [5:0]   lc_idx_q, lc_idx_d;
    logic [23:0]  lc_data_q, lc_data_d;

    logic       clr;
    logic       win;
    logic       acc;
    logic       push;
    logic       take;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] ph;
    logic [6:0] ix;
    pal_entry_t new_entry;
    pal_entry_t head;
    pal_entry_t out_entry;

    assign clr = reset | bus.dl_start;
    assign win = bus.hblank | bus.vblank | bus.video_reset;
    assign acc = bus.dl_wr & ~bus.dl_wait & ~reset;

    // A download restart behaves as if phase/index were already cleared,
    // so a byte arriving with dl_start lands as R of entry 0.
    assign ph = clr ? 2'd0 : phase_q;
    assign ix = clr ? 7'd0 : idx_q;

    assign new_entry = '{index: ix[5:0], rgb: {r_q, g_q, bus.dl_data}};

    always_comb begin
        phase_d   = ph;
        idx_d     = ix;
        r_d       = r_q;
        g_d       = g_q;
        push      = 1'b0;
        if (acc && ix != 7'(PAL_ENTRIES)) begin
            unique case (ph)
                2'd0: begin
                    r_d     = bus.dl_data;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    g_d     = bus.dl_data;
                    phase_d = 2'd2;
                end
                default: begin
                    push    = 1'b1;
                    phase_d = 2'd0;
                    idx_d   = ix + 7'd1;
                end
            endcase
        end
    end

    // An entry completing into an empty queue bypasses it, giving
    // one-cycle latency from the B byte to the palette write.
    always_comb begin
        take      = win & ~clr & (~fifo_empty | push);
        fifo_push = push & ~(take & fifo_empty);
        fifo_pop  = take & ~fifo_empty;
        out_entry = fifo_empty ? new_entry : head;
        state_d   = take ? WRITE : IDLE;
        lc_idx_d  = take ? out_entry.index : lc_idx_q;
        lc_data_d = take ? out_entry.rgb : lc_data_q;
        written_d = written_q;
        if (clr) begin
            written_d = 7'd0;
        end else if (bus.load_color && written_q != 7'(PAL_ENTRIES)) begin
            written_d = written_q + 7'd1;
        end
    end

    pal_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bus.dl_start),
        .push_i  (fifo_push),
        .din_i   (new_entry),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            r_q       <= '0;
            g_q       <= '0;
            idx_q     <= '0;
            written_q <= '0;
            lc_idx_q  <= '0;
            lc_data_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            r_q       <= r_d;
            g_q       <= g_d;
            idx_q     <= idx_d;
            written_q <= written_d;
            lc_idx_q  <= lc_idx_d;
            lc_data_q <= lc_data_d;
        end
    end

    // Once all entries are in, surplus bytes are swallowed without stalling.
    assign bus.dl_wait          = fifo_full & (idx_q != 7'(PAL_ENTRIES));
    assign bus.load_color       = (state_q == WRITE) & ~bus.dl_start;
    assign bus.load_color_index = lc_idx_q;
    assign bus.load_color_data  = lc_data_q;
    assign bus.done             = (written_q == 7'(PAL_ENTRIES));

endmodule
